pipelined_ripple_adder: RTL

- Parametrised, pipelined successor to the team's 16-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into WIDTH/CHUNK ripple-carry slices, with a register between slices. Throughput is one operation per clock.
- Valid/ready handshakes on both sides, so it drops into streaming datapaths.
- Adds a subtract mode and a signed-overflow flag.

---
 rtl/pipelined_ripple_adder.sv | 115 +++++++++++
 1 files changed

// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract: WIDTH bits split into WIDTH/CHUNK ripple-carry slices,
// one register per slice, valid/ready on both sides, carry-out and signed overflow.

module ripple_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic carry;

  always_comb begin
    s     = '0;
    carry = ci;
    c_msb = ci;
    for (int i = 0; i < CHUNK; i++) begin
      c_msb = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end
endmodule

module pipelined_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;

  // acc: finished low chunks plus untouched upper bits of a; bb: effective b.
  typedef struct packed {
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] bb;
    logic             c;
    logic             ovf;
  } stage_t;

  logic              adv;
  logic [STAGES-1:0] vld_pipe;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES-1];

  // Bubbles shift with the data; nothing moves while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t             src, nxt, q;
    logic               v_in;
    logic [CHUNK-1:0]   s;
    logic               co, c_msb;

    if (k == 0) begin : g_src
      // Subtract is a + ~b + 1, so cin is ignored when sub=1.
      assign src  = '{acc: a, bb: (sub ? ~b : b), c: (sub | cin), ovf: 1'b0};
      assign v_in = in_valid;
    end else begin : g_src
      assign src  = g_stage[k-1].q;
      assign v_in = vld_pipe[k-1];
    end

    ripple_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (src.acc[k*CHUNK +: CHUNK]),
      .b    (src.bb[k*CHUNK +: CHUNK]),
      .ci   (src.c),
      .s    (s),
      .co   (co),
      .c_msb(c_msb)
    );

    always_comb begin
      nxt                        = src;
      nxt.acc[k*CHUNK +: CHUNK]  = s;
      nxt.c                      = co;
      nxt.ovf                    = c_msb ^ co;
    end

    // Loading only valid data keeps the final register holding its last result.
    always_ff @(posedge clk) begin
      if (rst)               q <= '0;
      else if (adv && v_in)  q <= nxt;
    end
  end

  assign sum  = g_stage[STAGES-1].q.acc;
  assign cout = g_stage[STAGES-1].q.c;
  assign ovf  = g_stage[STAGES-1].q.ovf;
endmodule
